ldpc_frame_harness: RTL

// Parametrised frame-level harness between a word-serial LLR/bit source and the LDPC decoder core.

---
 rtl/ldpc_frame_harness.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ldpc_frame_harness.sv
// Frame harness: gathers W-bit beats into an N-bit frame, launches the
// LDPC decoder, guards it with a watchdog and keeps saturating run stats.
// Ports: clk, rst (sync, active-low); in_valid/in_ready/in_data source side;
// dec_start/dec_frame/dec_done/dec_success/dec_iterations decoder side;
// clear_stats; res_valid/res_success/res_timeout/res_iterations per frame;
// frame_count/fail_count/timeout_count/iter_sum/iter_max statistics.
module ldpc_frame_harness #(
  parameter int N            = 2048,
  parameter int W            = 64,
  parameter int MAX_ITER     = 30,
  parameter int LOG2MAX_ITER = 5,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    dec_start,
  output logic [N-1:0]            dec_frame,
  input  logic                    dec_done,
  input  logic                    dec_success,
  input  logic [LOG2MAX_ITER-1:0] dec_iterations,
  input  logic                    clear_stats,
  output logic                    res_valid,
  output logic                    res_success,
  output logic                    res_timeout,
  output logic [LOG2MAX_ITER-1:0] res_iterations,
  output logic [CNT_W-1:0]        frame_count,
  output logic [CNT_W-1:0]        fail_count,
  output logic [CNT_W-1:0]        timeout_count,
  output logic [CNT_W-1:0]        iter_sum,
  output logic [LOG2MAX_ITER-1:0] iter_max
);

  localparam int BEATS = N / W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int SW    = ((CNT_W > LOG2MAX_ITER) ? CNT_W : LOG2MAX_ITER) + 1;
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  typedef enum logic [1:0] {
    S_LOAD, S_LAUNCH, S_WAIT, S_REPORT
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [WD_W-1:0]         wdog_q;
  logic [N-1:0]            frame_q;
  logic                    in_ready_q;
  logic                    start_q;
  logic                    rvalid_q;
  logic                    rsucc_q;
  logic                    rto_q;
  logic [LOG2MAX_ITER-1:0] riter_q;

  logic [CNT_W-1:0]        frames_q, frames_d;
  logic [CNT_W-1:0]        fails_q, fails_d;
  logic [CNT_W-1:0]        tos_q, tos_d;
  logic [CNT_W-1:0]        isum_q, isum_d;
  logic [LOG2MAX_ITER-1:0] imax_q, imax_d;

  // Sum is one bit wider than either operand, so it cannot wrap
  // before the clamp test.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    logic [SW-1:0] s;
    s = a + b;
    if (s > CMAX) return '1;
    return s[CNT_W-1:0];
  endfunction

  // The watchdog counts cycles since dec_start: it is 0 in LAUNCH,
  // so expiry lands REPORT exactly TIMEOUT cycles after the pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      wdog_q     <= '0;
      frame_q    <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rsucc_q    <= 1'b0;
      rto_q      <= 1'b0;
      riter_q    <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            frame_q[idx_q*W +: W] <= in_data;
            if (idx_q == IDX_W'(BEATS-1)) begin
              idx_q      <= '0;
              wdog_q     <= '0;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              state_q    <= S_LAUNCH;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          start_q <= 1'b0;
          wdog_q  <= wdog_q + 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          if (dec_done) begin
            rvalid_q <= 1'b1;
            rsucc_q  <= dec_success;
            rto_q    <= 1'b0;
            riter_q  <= dec_iterations;
            state_q  <= S_REPORT;
          end else if (wdog_q == WD_W'(TIMEOUT-1)) begin
            rvalid_q <= 1'b1;
            rsucc_q  <= 1'b0;
            rto_q    <= 1'b1;
            riter_q  <= LOG2MAX_ITER'(MAX_ITER);
            state_q  <= S_REPORT;
          end
        end
        S_REPORT: begin
          rvalid_q   <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  always_comb begin
    frames_d = frames_q;
    fails_d  = fails_q;
    tos_d    = tos_q;
    isum_d   = isum_q;
    imax_d   = imax_q;
    if (state_q == S_REPORT) begin
      frames_d = sat_add(SW'(frames_q), SW'(1));
      fails_d  = sat_add(SW'(fails_q), SW'(!rsucc_q));
      tos_d    = sat_add(SW'(tos_q), SW'(rto_q));
      isum_d   = sat_add(SW'(isum_q), SW'(riter_q));
      if (riter_q > imax_q) imax_d = riter_q;
    end
  end

  // clear_stats deliberately overrides a same-cycle REPORT update.
  always_ff @(posedge clk) begin
    if (!rst || clear_stats) begin
      frames_q <= '0;
      fails_q  <= '0;
      tos_q    <= '0;
      isum_q   <= '0;
      imax_q   <= '0;
    end else begin
      frames_q <= frames_d;
      fails_q  <= fails_d;
      tos_q    <= tos_d;
      isum_q   <= isum_d;
      imax_q   <= imax_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign dec_start      = start_q;
  assign dec_frame      = frame_q;
  assign res_valid      = rvalid_q;
  assign res_success    = rsucc_q;
  assign res_timeout    = rto_q;
  assign res_iterations = riter_q;
  assign frame_count    = frames_q;
  assign fail_count     = fails_q;
  assign timeout_count  = tos_q;
  assign iter_sum       = isum_q;
  assign iter_max       = imax_q;

endmodule
